multicycle_control_fsm: RTL

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm_pkg.sv | 47 ++++
 rtl/multicycle_control_fsm_imm_src_decoder.sv | 19 +
 rtl/multicycle_control_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: states, opcodes
// and the datapath mux/ALU select codes driven by the controller.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
// Opcode to immediate-format decode; purely combinational.
module imm_src_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic [6:0] op_i,
   output logic [1:0] imm_src_o
);

   always_comb begin
      imm_src_o = IMM_I;
      case (op_i)
         OP_SW:   imm_src_o = IMM_S;
         OP_BEQ:  imm_src_o = IMM_B;
         OP_JAL:  imm_src_o = IMM_J;
         default: imm_src_o = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: state register, memory wait counter and
// per-state datapath control decode.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int unsigned MEM_LAT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] imm_dec;
   logic       wait_done;

   imm_src_decoder u_imm (
      .op_i      (op),
      .imm_src_o (imm_dec)
   );

   assign wait_done = (cnt_q == LAT);
   assign state     = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = S_FETCH;
      cnt_d     = '0;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ALUOp     = ALUOP_ADD;
      RegWrite  = 1'b0;
      ImmSrc    = imm_dec;
      retire    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            if (wait_done) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end else begin
               cnt_d   = cnt_q + 4'd1;
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            // Branch target PC+imm lands in ALUOut ahead of a possible BEQ.
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_IALU:      state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (wait_done) begin
               state_d = S_MEMWB;
            end else begin
               cnt_d   = cnt_q + 4'd1;
               state_d = S_MEMREAD;
            end
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            retire    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            retire   = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            ALUOp   = ALUOP_SUB;
            PCWrite = zero;
            retire  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
            state_d = S_ALUWB;
         end
         default: ImmSrc = IMM_I;
      endcase
      if (rst) begin
         PCWrite   = 1'b0;
         AdrSrc    = 1'b0;
         MemWrite  = 1'b0;
         IRWrite   = 1'b0;
         ResultSrc = RES_ALUOUT;
         ALUSrcA   = SRCA_PC;
         ALUSrcB   = SRCB_RD2;
         ALUOp     = ALUOP_ADD;
         RegWrite  = 1'b0;
         ImmSrc    = IMM_I;
         retire    = 1'b0;
         illegal   = 1'b0;
      end
   end

endmodule
